// File: rtl/aes_key_expand_pkg.sv
// Shared definitions for the AES key schedule: key-length codes, per-length
// sizes, FSM state type, S-box table and GF(2^8) helpers.
package aes_key_expand_pkg;

    localparam int NWORDS_MAX = 60;
    localparam int KEY_W      = 256;

    localparam logic [1:0] KEYLEN_NONE = 2'b00;
    localparam logic [1:0] KEYLEN_128  = 2'b01;
    localparam logic [1:0] KEYLEN_192  = 2'b10;
    localparam logic [1:0] KEYLEN_256  = 2'b11;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;
    localparam logic [5:0] NWORDS_128 = 6'd44;
    localparam logic [5:0] NWORDS_192 = 6'd52;
    localparam logic [5:0] NWORDS_256 = 6'd60;

    // state  | meaning
    // IDLE   | no key loaded since reset
    // EXPAND | one schedule word written per edge
    // DONE   | all Nr+1 round keys present, rekey allowed
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEYLEN_128: return NK_128;
            KEYLEN_192: return NK_192;
            KEYLEN_256: return NK_256;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEYLEN_128: return NR_128;
            KEYLEN_192: return NR_192;
            KEYLEN_256: return NR_256;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic [5:0] nwords_of(input logic [1:0] len);
        case (len)
            KEYLEN_128: return NWORDS_128;
            KEYLEN_192: return NWORDS_192;
            KEYLEN_256: return NWORDS_256;
            default:    return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_expand_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word, shared table with SubBytes.
module aes_subword
    import aes_key_expand_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule, one word per clock, with a zero-latency
// per-round-key read port so encryption can overlap with expansion.
module aes_key_expand
    import aes_key_expand_pkg::*;
#(
    parameter int NWORDS_MAX = aes_key_expand_pkg::NWORDS_MAX,
    parameter int KEY_W      = aes_key_expand_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key,
    input  logic [1:0]       key_len,
    input  logic             key_load,
    input  logic [3:0]       subkey_addr,
    output logic [127:0]     subkey,
    output logic             subkey_valid,
    output logic             busy,
    output logic             key_ready
);

    state_e      state_q, state_d;
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic [5:0]  total_q, total_d;
    logic [5:0]  words_done_q, words_done_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  j_q, j_d;
    logic [7:0]  rcon_q, rcon_d;
    logic [31:0] store_q [NWORDS_MAX];

    logic        accept;
    logic        last_word;
    logic [3:0]  key_nk;
    logic [5:0]  prev_idx, back_idx, rd_base;
    logic [31:0] w_prev, w_back, sub_in, sub_out, t, w_new;
    logic [6:0]  need_words;

    assign key_nk    = nk_of(key_len);
    assign accept    = key_load && (key_len != KEYLEN_NONE) && (state_q != EXPAND);
    assign last_word = (state_q == EXPAND) && (i_q == total_q - 6'd1);

    assign prev_idx = i_q - 6'd1;
    assign back_idx = i_q - {2'b00, nk_q};
    assign w_prev   = store_q[prev_idx];
    assign w_back   = store_q[back_idx];
    assign sub_in   = (j_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_subword u_subword (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    always_comb begin
        t = w_prev;
        if (j_q == 3'd0) begin
            t = sub_out ^ {rcon_q, 24'h0};
        end else if ((nk_q == NK_256) && (j_q == 3'd4)) begin
            t = sub_out;
        end
    end

    assign w_new = w_back ^ t;

    always_comb begin
        state_d      = state_q;
        nk_d         = nk_q;
        nr_d         = nr_q;
        total_d      = total_q;
        words_done_d = words_done_q;
        i_d          = i_q;
        j_d          = j_q;
        rcon_d       = rcon_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d      = EXPAND;
                    nk_d         = key_nk;
                    nr_d         = nr_of(key_len);
                    total_d      = nwords_of(key_len);
                    words_done_d = {2'b00, key_nk};
                    i_d          = {2'b00, key_nk};
                    j_d          = 3'd0;
                    rcon_d       = 8'h01;
                end
            end
            EXPAND: begin
                words_done_d = words_done_q + 6'd1;
                j_d          = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                // i parks on the last word index rather than running past the store
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    i_d = i_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            nk_q         <= '0;
            nr_q         <= '0;
            total_q      <= '0;
            words_done_q <= '0;
            i_q          <= '0;
            j_q          <= '0;
            rcon_q       <= '0;
        end else begin
            state_q      <= state_d;
            nk_q         <= nk_d;
            nr_q         <= nr_d;
            total_q      <= total_d;
            words_done_q <= words_done_d;
            i_q          <= i_d;
            j_q          <= j_d;
            rcon_q       <= rcon_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NWORDS_MAX; k++) begin
                store_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < key_nk) begin
                    store_q[k] <= key[KEY_W-1-32*k -: 32];
                end
            end
        end else if (state_q == EXPAND) begin
            store_q[i_q] <= w_new;
        end
    end

    assign rd_base = {subkey_addr, 2'b00};

    always_comb begin
        subkey = '0;
        if (subkey_addr <= NR_256) begin
            subkey = {store_q[rd_base],         store_q[rd_base + 6'd1],
                      store_q[rd_base + 6'd2],  store_q[rd_base + 6'd3]};
        end
    end

    assign need_words   = {1'b0, subkey_addr, 2'b00} + 7'd4;
    assign subkey_valid = (subkey_addr <= nr_q) && (need_words <= {1'b0, words_done_q});
    assign busy         = (state_q == EXPAND);
    assign key_ready    = (state_q == DONE);

endmodule
